// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA timing generator: axis state encoding,
// 640x480@60 default timing and the line/frame total helper.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } axis_state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Control and video-timing bundle between the timing generator (master)
// and the display path consuming it (slave).
interface vga_timing_gen_if #(
  parameter int CNT_WIDTH = 11,
  parameter int X_WIDTH   = 8,
  parameter int Y_WIDTH   = 8
);
  logic                 iEnable;
  logic                 oPixelCE;
  logic [CNT_WIDTH-1:0] oHCount;
  logic [CNT_WIDTH-1:0] oVCount;
  logic                 oVGAHorizontalSync;
  logic                 oVGAVerticalSync;
  logic                 oDisplay;
  logic [X_WIDTH-1:0]   oVideoMemCol;
  logic [Y_WIDTH-1:0]   oVideoMemRow;
  logic                 oLineStart;
  logic                 oFrameStart;

  modport master (
    input  iEnable,
    output oPixelCE, oHCount, oVCount, oVGAHorizontalSync, oVGAVerticalSync,
           oDisplay, oVideoMemCol, oVideoMemRow, oLineStart, oFrameStart
  );

  modport slave (
    output iEnable,
    input  oPixelCE, oHCount, oVCount, oVGAHorizontalSync, oVGAVerticalSync,
           oDisplay, oVideoMemCol, oVideoMemRow, oLineStart, oFrameStart
  );
endinterface

// File: rtl/vga_axis_fsm.sv
// One timing axis: ACTIVE -> FRONT -> SYNC -> BACK state machine plus the
// position counter that runs 0..TOTAL-1 and wraps.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE    = 640,
  parameter int FP        = 16,
  parameter int SYNC      = 96,
  parameter int BP        = 48,
  parameter int CNT_WIDTH = 11
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 step,
  input  logic                 enable,
  output logic [CNT_WIDTH-1:0] count,
  output axis_state_e          state,
  output logic                 wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_length
    $error("vga_axis_fsm: active, porch and sync lengths must all be at least 1");
  end
  if (TOTAL > (2 ** CNT_WIDTH)) begin : g_bad_width
    $error("vga_axis_fsm: CNT_WIDTH too small for the axis total");
  end

  axis_state_e          state_d;
  logic [CNT_WIDTH-1:0] phase;      // position inside the current state
  logic [CNT_WIDTH-1:0] state_len;
  logic                 advance;
  logic                 state_last;

  assign advance    = step && enable;
  assign state_last = (phase == state_len - 1'b1);
  assign wrap       = (count == CNT_WIDTH'(TOTAL - 1));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_len = CNT_WIDTH'(ACTIVE);
    state_d   = state;
    case (state)
      ST_FRONT: state_len = CNT_WIDTH'(FP);
      ST_SYNC:  state_len = CNT_WIDTH'(SYNC);
      ST_BACK:  state_len = CNT_WIDTH'(BP);
      default:  state_len = CNT_WIDTH'(ACTIVE);
    endcase
    if (advance && state_last) begin
      case (state)
        ST_ACTIVE: state_d = ST_FRONT;
        ST_FRONT:  state_d = ST_SYNC;
        ST_SYNC:   state_d = ST_BACK;
        default:   state_d = ST_ACTIVE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ACTIVE;
      phase <= '0;
      count <= '0;
    end else if (advance) begin
      state <= state_d;
      phase <= state_last ? '0 : phase + 1'b1;
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: pixel clock-enable divider, H/V axis
// machines and registered sync, window, address and strobe outputs.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HS_POL      = 1'b0,
  parameter bit VS_POL      = 1'b0,
  parameter int X_WIDTH     = 8,
  parameter int Y_WIDTH     = 8,
  parameter int X_SIZE      = 256,
  parameter int Y_SIZE      = 256,
  parameter int SCALE_SHIFT = 0,
  parameter int CNT_WIDTH   = 11
) (
  input  logic             Clock,
  input  logic             Reset,
  vga_timing_gen_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  // Framebuffer window in screen pixels, clipped to the visible area.
  localparam int H_WIN = ((X_SIZE << SCALE_SHIFT) < H_ACTIVE) ? (X_SIZE << SCALE_SHIFT) : H_ACTIVE;
  localparam int V_WIN = ((Y_SIZE << SCALE_SHIFT) < V_ACTIVE) ? (Y_SIZE << SCALE_SHIFT) : V_ACTIVE;

  if (CLK_DIV < 1) begin : g_bad_div
    $error("vga_timing_gen: CLK_DIV must be at least 1");
  end

  logic                 enable, ce, in_win;
  logic [DIV_W-1:0]     div;
  logic [CNT_WIDTH-1:0] hcount, vcount;
  axis_state_e          h_state, v_state;
  logic                 h_wrap, v_wrap;
  logic                 pixel_ce_q, hs_q, vs_q, disp_q, line_q, frame_q;
  logic [X_WIDTH-1:0]   col_q;
  logic [Y_WIDTH-1:0]   row_q;

  assign enable = bus.iEnable;
  assign ce     = enable && (div == DIV_LAST);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset)      div <= '0;
    else if (enable) div <= (div == DIV_LAST) ? '0 : div + 1'b1;
  end

  vga_axis_fsm #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CNT_WIDTH(CNT_WIDTH)
  ) u_h_axis (
    .clk(Clock), .rst_n(Reset), .step(ce), .enable(enable),
    .count(hcount), .state(h_state), .wrap(h_wrap)
  );

  vga_axis_fsm #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CNT_WIDTH(CNT_WIDTH)
  ) u_v_axis (
    .clk(Clock), .rst_n(Reset), .step(ce && h_wrap), .enable(enable),
    .count(vcount), .state(v_state), .wrap(v_wrap)
  );

  assign in_win = (h_state == ST_ACTIVE) && (v_state == ST_ACTIVE) &&
                  (hcount < CNT_WIDTH'(H_WIN)) && (vcount < CNT_WIDTH'(V_WIN));

  // Outputs decode the counters one clock late; a disabled generator looks idle.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset || !enable) begin
      pixel_ce_q <= 1'b0;
      hs_q       <= ~HS_POL;
      vs_q       <= ~VS_POL;
      disp_q     <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      pixel_ce_q <= ce;
      hs_q       <= (h_state == ST_SYNC) ? HS_POL : ~HS_POL;
      vs_q       <= (v_state == ST_SYNC) ? VS_POL : ~VS_POL;
      disp_q     <= in_win;
      col_q      <= in_win ? X_WIDTH'(hcount >> SCALE_SHIFT) : '0;
      row_q      <= in_win ? Y_WIDTH'(vcount >> SCALE_SHIFT) : '0;
      line_q     <= (hcount == '0);
      frame_q    <= (hcount == '0) && (vcount == '0);
    end
  end

  a_frame_wrap: assert property (@(posedge Clock) disable iff (!Reset)
    (ce && h_wrap && v_wrap) |=> (hcount == '0 && vcount == '0));

  assign bus.oPixelCE           = pixel_ce_q;
  assign bus.oHCount            = hcount;
  assign bus.oVCount            = vcount;
  assign bus.oVGAHorizontalSync = hs_q;
  assign bus.oVGAVerticalSync   = vs_q;
  assign bus.oDisplay           = disp_q;
  assign bus.oVideoMemCol       = col_q;
  assign bus.oVideoMemRow       = row_q;
  assign bus.oLineStart         = line_q;
  assign bus.oFrameStart        = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen on a 14x8 timing grid, CLK_DIV=2,
// 4x2 framebuffer at 2x scale.
module tb_vga_timing_gen;

  localparam int CW = 11;
  localparam int XW = 8;
  localparam int YW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  vga_timing_gen_if #(.CNT_WIDTH(CW), .X_WIDTH(XW), .Y_WIDTH(YW)) bus ();

  vga_timing_gen #(
    .CLK_DIV(2),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0),
    .X_WIDTH(XW), .Y_WIDTH(YW), .X_SIZE(4), .Y_SIZE(2),
    .SCALE_SHIFT(1), .CNT_WIDTH(CW)
  ) dut (
    .Clock(clk),
    .Reset(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int step_no, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%0d expected=%0d", tag, step_no, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input int step_no);
    check("rst_pixel_ce", step_no, 32'(bus.oPixelCE), 32'd0);
    check("rst_hcount", step_no, 32'(bus.oHCount), 32'd0);
    check("rst_vcount", step_no, 32'(bus.oVCount), 32'd0);
    check("rst_hsync", step_no, 32'(bus.oVGAHorizontalSync), 32'd1);
    check("rst_vsync", step_no, 32'(bus.oVGAVerticalSync), 32'd1);
    check("rst_display", step_no, 32'(bus.oDisplay), 32'd0);
    check("rst_col", step_no, 32'(bus.oVideoMemCol), 32'd0);
    check("rst_row", step_no, 32'(bus.oVideoMemRow), 32'd0);
    check("rst_line_start", step_no, 32'(bus.oLineStart), 32'd0);
    check("rst_frame_start", step_no, 32'(bus.oFrameStart), 32'd0);
  endtask

  // Expected values k clocks after reset release: counters move on even clocks,
  // registered outputs show the position held during the previous clock.
  task automatic check_cycle(input int k);
    int   hp, vp, hc, vc;
    logic disp;
    hc   = (k / 2) % 14;
    vc   = (k / 28) % 8;
    hp   = ((k - 1) / 2) % 14;
    vp   = ((k - 1) / 28) % 8;
    disp = (hp < 8) && (vp < 4);
    check("pixel_ce", k, 32'(bus.oPixelCE), 32'((k % 2) == 0));
    check("hcount", k, 32'(bus.oHCount), 32'(hc));
    check("vcount", k, 32'(bus.oVCount), 32'(vc));
    check("hsync", k, 32'(bus.oVGAHorizontalSync), 32'(!(hp >= 10 && hp <= 12)));
    check("vsync", k, 32'(bus.oVGAVerticalSync), 32'(!(vp >= 5 && vp <= 6)));
    check("display", k, 32'(bus.oDisplay), 32'(disp));
    check("col", k, 32'(bus.oVideoMemCol), disp ? 32'(hp / 2) : 32'd0);
    check("row", k, 32'(bus.oVideoMemRow), disp ? 32'(vp / 2) : 32'd0);
    check("line_start", k, 32'(bus.oLineStart), 32'(hp == 0));
    check("frame_start", k, 32'(bus.oFrameStart), 32'(hp == 0 && vp == 0));
  endtask

  initial begin
    int   hs_low, vs_low, ls_rises, fs_rises, fs_first, fs_second;
    logic ls_prev, fs_prev;
    hs_low = 0; vs_low = 0; ls_rises = 0; fs_rises = 0; fs_first = 0; fs_second = 0;
    ls_prev = 1'b0; fs_prev = 1'b0;

    // Reset held across clock edges.
    bus.iEnable = 1'b1;
    repeat (3) step();
    check_reset(0);

    // Release away from the edge; first CE lands on the second clock.
    #2 rst_n = 1'b1;
    step();
    check("first_ce_clock1", 1, 32'(bus.oPixelCE), 32'd0);
    check("hold_hcount_clock1", 1, 32'(bus.oHCount), 32'd0);
    check_cycle(1);
    fs_rises = 1; fs_first = 1; fs_prev = bus.oFrameStart;
    ls_rises = 1; ls_prev = bus.oLineStart;
    if (!bus.oVGAHorizontalSync) hs_low++;
    if (!bus.oVGAVerticalSync) vs_low++;
    step();
    check("first_ce_clock2", 2, 32'(bus.oPixelCE), 32'd1);
    check_cycle(2);

    // Run past one full frame, up to the clock where hcount has just become 5.
    for (int k = 3; k <= 262; k++) begin
      if (k == 3) begin
        ls_prev = bus.oLineStart;
        fs_prev = bus.oFrameStart;
        if (!bus.oVGAHorizontalSync) hs_low++;
        if (!bus.oVGAVerticalSync) vs_low++;
      end
      step();
      check_cycle(k);
      if (k <= 28 && !bus.oVGAHorizontalSync) hs_low++;
      if (k <= 224 && !bus.oVGAVerticalSync) vs_low++;
      if (k <= 28 && bus.oLineStart && !ls_prev) ls_rises++;
      if (bus.oFrameStart && !fs_prev) begin
        fs_rises++;
        if (fs_rises == 2) fs_second = k;
      end
      ls_prev = bus.oLineStart;
      fs_prev = bus.oFrameStart;
    end
    check("hsync_low_clocks_line0", 28, 32'(hs_low), 32'd6);
    check("vsync_low_clocks_frame0", 224, 32'(vs_low), 32'd56);
    check("line_start_pulses_line0", 28, 32'(ls_rises), 32'd1);
    check("frame_start_pulses", 262, 32'(fs_rises), 32'd2);
    check("frame_period_clocks", 262, 32'(fs_second - fs_first), 32'd224);

    // Freeze for 10 clocks at hcount=5 on line 1.
    bus.iEnable = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("freeze_hcount", i, 32'(bus.oHCount), 32'd5);
      check("freeze_vcount", i, 32'(bus.oVCount), 32'd1);
      check("freeze_hsync", i, 32'(bus.oVGAHorizontalSync), 32'd1);
      check("freeze_vsync", i, 32'(bus.oVGAVerticalSync), 32'd1);
      check("freeze_display", i, 32'(bus.oDisplay), 32'd0);
      check("freeze_pixel_ce", i, 32'(bus.oPixelCE), 32'd0);
      check("freeze_line_start", i, 32'(bus.oLineStart), 32'd0);
      check("freeze_col", i, 32'(bus.oVideoMemCol), 32'd0);
    end

    // Resume exactly where the freeze left off.
    bus.iEnable = 1'b1;
    step();
    check("resume_hcount_clock1", 263, 32'(bus.oHCount), 32'd5);
    check_cycle(263);
    step();
    check("resume_hcount_clock2", 264, 32'(bus.oHCount), 32'd6);
    check_cycle(264);
    for (int k = 265; k <= 326; k++) begin
      step();
      check_cycle(k);
    end
    check("pre_reset_hcount", 326, 32'(bus.oHCount), 32'd9);
    check("pre_reset_vcount", 326, 32'(bus.oVCount), 32'd3);

    // Asynchronous reset between clock edges.
    #2 rst_n = 1'b0;
    #1;
    check_reset(327);
    repeat (2) step();
    check_reset(328);

    #2 rst_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step();
      check_cycle(k);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
